// File: rtl/chi_rx_link_buffer_pkg.sv
// Shared types and limits for the CHI receive link buffer.
package chi_rx_link_buffer_pkg;

  localparam int unsigned CHI_MAX_LCRD = 15;

  typedef logic [3:0] lcrd_cnt_t;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [31:0] addr;
  } request_flit_t;

endpackage

// File: rtl/chi_rx_link_buffer_if.sv
// Receive-side link signals plus the protocol-layer dequeue handshake.
interface chi_rx_link_buffer_if
  import chi_rx_link_buffer_pkg::*;
#(
  parameter type         FLIT_T = request_flit_t,
  parameter int unsigned DEPTH  = 4
) ();

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          link_en;
  logic          rx_flit_pend;
  logic          rx_flit_v;
  FLIT_T         rx_flit;
  logic          rx_lcrd_v;
  logic          deq_valid;
  logic          deq_ready;
  FLIT_T         deq_flit;
  logic [CW-1:0] credits_out;
  logic          ovf_err;

  modport master (
    output link_en, rx_flit_pend, rx_flit_v, rx_flit, deq_ready,
    input  rx_lcrd_v, deq_valid, deq_flit, credits_out, ovf_err
  );

  modport slave (
    input  link_en, rx_flit_pend, rx_flit_v, rx_flit, deq_ready,
    output rx_lcrd_v, deq_valid, deq_flit, credits_out, ovf_err
  );

endinterface

// File: rtl/chi_rx_link_buffer_fifo.sv
// Registered synchronous flit FIFO; pointers wrap modulo DEPTH (any DEPTH).
module chi_flit_fifo
  import chi_rx_link_buffer_pkg::*;
#(
  parameter type         FLIT_T = request_flit_t,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  FLIT_T                        push_data_i,
  input  logic                         pop_i,
  output FLIT_T                        pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  FLIT_T         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign cnt_o      = cnt_q;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  // Output forced to zero while empty so the head reads 0 out of reset.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/chi_rx_link_buffer.sv
// CHI link-layer receiver: credit-sized flit buffer issuing one L-credit per free entry.
module chi_rx_link_buffer
  import chi_rx_link_buffer_pkg::*;
#(
  parameter type         FLIT_T = request_flit_t,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  chi_rx_link_buffer_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] fifo_cnt, cnt_nxt;
  logic          lcrd_q, lcrd_d;
  logic          ovf_q, ovf_d;
  logic          enq, deq;
  logic          fifo_full, fifo_empty;
  logic          unused_pend;

  // rx_flit_pend is only a clock-gating hint for the transmitter side.
  assign unused_pend = bus.rx_flit_pend;

  assign enq = bus.rx_flit_v && (credits_q != '0);
  assign deq = !fifo_empty && bus.deq_ready;

  chi_flit_fifo #(
    .FLIT_T (FLIT_T),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (enq),
    .push_data_i (bus.rx_flit),
    .pop_i       (deq),
    .pop_data_o  (bus.deq_flit),
    .cnt_o       (fifo_cnt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.deq_valid   = !fifo_empty;
  assign bus.rx_lcrd_v   = lcrd_q;
  assign bus.credits_out = credits_q;
  assign bus.ovf_err     = ovf_q;

  // Credit accounting: grant only while outstanding credits plus occupancy stay below DEPTH.
  always_comb begin
    credits_d = credits_q + CW'(lcrd_q) - CW'(enq);
    cnt_nxt   = fifo_cnt + CW'(enq) - CW'(deq);
    lcrd_d    = bus.link_en && (({1'b0, credits_d} + {1'b0, cnt_nxt}) < SW'(DEPTH));
    ovf_d     = ovf_q | (bus.rx_flit_v && (credits_q == '0));
  end

  // Credit counter, grant register and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= '0;
      lcrd_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      lcrd_q    <= lcrd_d;
      ovf_q     <= ovf_d;
    end
  end

  // Full with credits outstanding would break the credit invariant.
  assert property (@(posedge clk) disable iff (rst) fifo_full |-> (credits_q == '0));

endmodule
